// File: rtl/ofs_asp_pkg.sv
// Shared definitions for the host memory write arbiter.
// Holds the default interface widths and the arbiter FSM state encoding.
package ofs_asp_pkg;

    localparam int DEF_NUM_REQ         = 2;
    localparam int DEF_ADDR_WIDTH      = 48;
    localparam int DEF_DATA_WIDTH      = 512;
    localparam int DEF_BURST_CNT_WIDTH = 6;
    localparam int DEF_RSP_FIFO_DEPTH  = 64;

    // Arbiter FSM states
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

endpackage

// File: rtl/host_mem_wr_rsp_fifo.sv
// Response-ID FIFO: records which requester owns each outstanding host burst.
// Synchronous FIFO with show-ahead head and full/empty flags.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (empties the FIFO)
//   push       : write push_data (ignored when full unless popping)
//   pop        : discard head (ignored when empty)
//   head       : current head entry, valid when !empty
//   full/empty : occupancy flags
module host_mem_wr_rsp_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);
    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/host_mem_wr_arb.sv
// Round-robin arbiter merging NUM_REQ Avalon-MM burst writers onto one host
// write port and routing each host write response back to its issuer.
// Ports:
//   pClk, pClk_reset        : clock, asynchronous active-high reset
//   req_*                   : per-requester write port (packed NUM_REQ x field)
//   req_writeresponsevalid  : per-requester completion pulse
//   host_*                  : merged host write port
//   rsp_underflow_err       : sticky, response seen with nothing outstanding
module host_mem_wr_arb
    import ofs_asp_pkg::*;
#(
    parameter int NUM_REQ         = DEF_NUM_REQ,
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int BURST_CNT_WIDTH = DEF_BURST_CNT_WIDTH,
    parameter int RSP_FIFO_DEPTH  = DEF_RSP_FIFO_DEPTH
) (
    input  logic                                  pClk,
    input  logic                                  pClk_reset,
    input  logic [NUM_REQ-1:0]                    req_write,
    output logic [NUM_REQ-1:0]                    req_waitrequest,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]         req_address,
    input  logic [NUM_REQ*BURST_CNT_WIDTH-1:0]    req_burstcount,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]         req_writedata,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]     req_byteenable,
    output logic [NUM_REQ-1:0]                    req_writeresponsevalid,
    output logic                                  host_write,
    output logic [ADDR_WIDTH-1:0]                 host_address,
    output logic [BURST_CNT_WIDTH-1:0]            host_burstcount,
    output logic [DATA_WIDTH-1:0]                 host_writedata,
    output logic [DATA_WIDTH/8-1:0]               host_byteenable,
    input  logic                                  host_waitrequest,
    input  logic                                  host_writeresponsevalid,
    output logic                                  rsp_underflow_err
);

    localparam int GW  = $clog2(NUM_REQ);
    localparam int BEW = DATA_WIDTH / 8;

    logic [0:0]                 state_q;
    logic [GW-1:0]              grant_q;
    logic [GW-1:0]              ptr_q;
    logic [BURST_CNT_WIDTH-1:0] cnt_q;
    logic                       first_q;
    logic                       err_q;

    logic [GW-1:0]              rr_sel;
    logic                       rr_found;
    int unsigned                rr_idx;
    logic                       beat;
    logic                       last_beat;
    logic                       fifo_push;
    logic                       fifo_pop;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [GW-1:0]              fifo_head;

    // First requesting index at or after the priority pointer.
    always_comb begin
        rr_found = 1'b0;
        rr_sel   = '0;
        rr_idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rr_idx = (32'(ptr_q) + i) % NUM_REQ;
            if (!rr_found && req_write[rr_idx]) begin
                rr_found = 1'b1;
                rr_sel   = GW'(rr_idx);
            end
        end
    end

    // The datapath always follows the grant; host_write gates it outside BURST.
    assign host_address    = req_address[grant_q*ADDR_WIDTH +: ADDR_WIDTH];
    assign host_burstcount = req_burstcount[grant_q*BURST_CNT_WIDTH +: BURST_CNT_WIDTH];
    assign host_writedata  = req_writedata[grant_q*DATA_WIDTH +: DATA_WIDTH];
    assign host_byteenable = req_byteenable[grant_q*BEW +: BEW];
    assign host_write      = (state_q == ST_BURST) && req_write[grant_q];

    assign beat      = host_write && !host_waitrequest;
    assign fifo_push = beat && first_q;
    // cnt_q holds the beats still owed after the last accepted one.
    assign last_beat = beat && (first_q ? (host_burstcount <= BURST_CNT_WIDTH'(1))
                                        : (cnt_q <= BURST_CNT_WIDTH'(1)));
    assign fifo_pop  = host_writeresponsevalid && !fifo_empty;
    assign rsp_underflow_err = err_q;

    always_comb begin
        req_waitrequest = '1;
        if (state_q == ST_BURST) req_waitrequest[grant_q] = host_waitrequest;
    end

    always_comb begin
        req_writeresponsevalid = '0;
        if (fifo_pop) req_writeresponsevalid[fifo_head] = 1'b1;
    end

    always_ff @(posedge pClk or posedge pClk_reset) begin
        if (pClk_reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (host_writeresponsevalid && fifo_empty) err_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (rr_found && !fifo_full) begin
                        state_q <= ST_BURST;
                        grant_q <= rr_sel;
                        ptr_q   <= (rr_sel == GW'(NUM_REQ - 1)) ? '0 : rr_sel + 1'b1;
                        first_q <= 1'b1;
                    end
                end
                ST_BURST: begin
                    if (beat) begin
                        first_q <= 1'b0;
                        if (last_beat) begin
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= first_q ? host_burstcount - 1'b1 : cnt_q - 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    host_mem_wr_rsp_fifo #(
        .DEPTH(RSP_FIFO_DEPTH),
        .WIDTH(GW)
    ) u_rsp_fifo (
        .clk       (pClk),
        .rst       (pClk_reset),
        .push      (fifo_push),
        .push_data (grant_q),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_host_mem_wr_arb.sv
// Self-checking bench for host_mem_wr_arb: reset vector table, directed
// scenarios and randomized traffic checked cycle by cycle against a queue model.
module tb_host_mem_wr_arb;

    localparam int NR    = 2;
    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int BCW   = 6;
    localparam int DEPTH = 4;
    localparam int BEW   = DW / 8;

    logic              pClk = 1'b0;
    logic              pClk_reset;
    logic [NR-1:0]     req_write;
    logic [NR-1:0]     req_waitrequest;
    logic [NR*AW-1:0]  req_address;
    logic [NR*BCW-1:0] req_burstcount;
    logic [NR*DW-1:0]  req_writedata;
    logic [NR*BEW-1:0] req_byteenable;
    logic [NR-1:0]     req_writeresponsevalid;
    logic              host_write;
    logic [AW-1:0]     host_address;
    logic [BCW-1:0]    host_burstcount;
    logic [DW-1:0]     host_writedata;
    logic [BEW-1:0]    host_byteenable;
    logic              host_waitrequest;
    logic              host_writeresponsevalid;
    logic              rsp_underflow_err;

    always #5 pClk = ~pClk;

    host_mem_wr_arb #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .BURST_CNT_WIDTH(BCW), .RSP_FIFO_DEPTH(DEPTH)
    ) dut (
        .pClk                    (pClk),
        .pClk_reset              (pClk_reset),
        .req_write               (req_write),
        .req_waitrequest         (req_waitrequest),
        .req_address             (req_address),
        .req_burstcount          (req_burstcount),
        .req_writedata           (req_writedata),
        .req_byteenable          (req_byteenable),
        .req_writeresponsevalid  (req_writeresponsevalid),
        .host_write              (host_write),
        .host_address            (host_address),
        .host_burstcount         (host_burstcount),
        .host_writedata          (host_writedata),
        .host_byteenable         (host_byteenable),
        .host_waitrequest        (host_waitrequest),
        .host_writeresponsevalid (host_writeresponsevalid),
        .rsp_underflow_err       (rsp_underflow_err)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Requester masters and host responder controls
    int            pend [NR][$];
    int            cur_left [NR];
    int            cur_bc [NR];
    int            cur_beat [NR];
    int            cur_id [NR];
    logic [AW-1:0] cur_addr [NR];
    logic          acc [NR];
    int            hw_mode = 0;
    int            rsp_mode = 0;
    int            force_rsp = 0;
    bit            gap_en = 0;

    // Reference model: owner (-1 = none), pointer, beats owed, outstanding IDs
    int m_owner = -1;
    int m_ptr = 0;
    int m_left = 0;
    bit m_first = 0;
    bit m_err = 0;
    int m_q[$];

    // Observation logs
    int grant_log[$];
    int rsp_log[$];
    int beat_log[$];
    bit hw_hist[$];
    bit rw_hist[$];
    int host_beats = 0;
    int rsp_cnt [NR];
    bit prev_any_low = 0;

    logic [NR-1:0] ew, ersp;
    logic          ehw;
    int            c, bcv, low_idx;
    bit            full_now;

    always @(negedge pClk) begin
        if (pClk_reset) begin
            m_owner = -1; m_ptr = 0; m_left = 0; m_first = 0; m_err = 0;
            m_q.delete();
            prev_any_low = 0;
        end
        ew = '1;
        if (m_owner >= 0) ew[m_owner] = host_waitrequest;
        ehw = (m_owner >= 0) && req_write[m_owner];
        ersp = '0;
        if (host_writeresponsevalid && m_q.size() > 0) ersp[m_q[0]] = 1'b1;

        chk("waitrequest", 64'(req_waitrequest), 64'(ew));
        chk("host_write", 64'(host_write), 64'(ehw));
        if (ehw) begin
            chk("host_address", 64'(host_address), 64'(req_address[m_owner*AW +: AW]));
            chk("host_burstcount", 64'(host_burstcount),
                64'(req_burstcount[m_owner*BCW +: BCW]));
            chk("host_writedata", 64'(host_writedata), 64'(req_writedata[m_owner*DW +: DW]));
            chk("host_byteenable", 64'(host_byteenable),
                64'(req_byteenable[m_owner*BEW +: BEW]));
        end
        chk("rsp_valid", 64'(req_writeresponsevalid), 64'(ersp));
        chk("underflow_err", 64'(rsp_underflow_err), 64'(m_err));

        for (int i = 0; i < NR; i++) begin
            acc[i] = req_write[i] && !req_waitrequest[i];
            if (req_writeresponsevalid[i]) begin
                rsp_log.push_back(i);
                rsp_cnt[i]++;
            end
        end
        if (host_write && !host_waitrequest) begin
            host_beats++;
            beat_log.push_back(int'(host_writedata[DW-1:DW-8]));
        end
        low_idx = -1;
        for (int i = 0; i < NR; i++) if (!req_waitrequest[i]) low_idx = i;
        if (low_idx >= 0 && !prev_any_low) grant_log.push_back(low_idx);
        prev_any_low = (low_idx >= 0);

        if (!pClk_reset) begin
            hw_hist.push_back(host_write);
            rw_hist.push_back(req_write[0]);
            full_now = (m_q.size() >= DEPTH);
            if (host_writeresponsevalid) begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                else m_err = 1;
            end
            if (m_owner < 0) begin
                if (!full_now) begin
                    for (int k = 0; k < NR; k++) begin
                        c = (m_ptr + k) % NR;
                        if (m_owner < 0 && req_write[c]) begin
                            m_owner = c;
                            m_ptr = (c + 1) % NR;
                            m_first = 1;
                        end
                    end
                end
            end else if (ehw && !host_waitrequest) begin
                if (m_first) begin
                    bcv = int'(req_burstcount[m_owner*BCW +: BCW]);
                    m_q.push_back(m_owner);
                    m_left = bcv - 1;
                    m_first = 0;
                end else begin
                    m_left--;
                end
                if (m_left <= 0) m_owner = -1;
            end
        end
    end

    logic [NR-1:0]     d_wr;
    logic [NR*AW-1:0]  d_addr;
    logic [NR*BCW-1:0] d_bc;
    logic [NR*DW-1:0]  d_data;
    logic [NR*BEW-1:0] d_be;

    task automatic drive_step();
        for (int i = 0; i < NR; i++) begin
            if (pClk_reset) begin
                pend[i].delete();
                cur_left[i] = 0;
            end else if (acc[i] && cur_left[i] > 0) begin
                cur_left[i]--;
                cur_beat[i]++;
            end
            if (cur_left[i] == 0 && pend[i].size() > 0) begin
                cur_bc[i] = pend[i].pop_front();
                cur_left[i] = cur_bc[i];
                cur_beat[i] = 0;
                cur_id[i]++;
                cur_addr[i] = AW'($urandom);
            end
            d_wr[i] = (cur_left[i] > 0) && !(gap_en && $urandom_range(0, 3) == 0);
            d_addr[i*AW +: AW] = cur_addr[i];
            // Burstcount is scrambled after the first beat: the DUT must ignore it.
            d_bc[i*BCW +: BCW] = (cur_beat[i] == 0) ? BCW'(cur_bc[i]) : BCW'($urandom);
            d_data[i*DW +: DW] = {8'(i), 8'(cur_id[i]), 16'(cur_beat[i])};
            d_be[i*BEW +: BEW] = BEW'($urandom);
        end
        req_write = d_wr;
        req_address = d_addr;
        req_burstcount = d_bc;
        req_writedata = d_data;
        req_byteenable = d_be;
        case (hw_mode)
            0:       host_waitrequest = 1'b0;
            1:       host_waitrequest = ($urandom_range(0, 2) == 0);
            default: host_waitrequest = ~host_waitrequest;
        endcase
        if (force_rsp > 0) begin
            host_writeresponsevalid = 1'b1;
            force_rsp--;
        end else begin
            host_writeresponsevalid = (rsp_mode != 0) && (m_q.size() > 0) &&
                                      ($urandom_range(0, 1) == 0);
        end
    endtask

    task automatic clear_logs();
        grant_log.delete(); rsp_log.delete(); beat_log.delete();
        hw_hist.delete(); rw_hist.delete();
        host_beats = 0;
        for (int i = 0; i < NR; i++) rsp_cnt[i] = 0;
    endtask

    task automatic do_reset();
        @(negedge pClk); #2;
        pClk_reset = 1'b1;
        repeat (2) @(posedge pClk);
        @(negedge pClk); #2;
        hw_mode = 0; rsp_mode = 0; gap_en = 0; force_rsp = 0;
        clear_logs();
        pClk_reset = 1'b0;
    endtask

    typedef struct {
        logic [NR-1:0] wr;
        logic          hwait;
        logic          hrsp;
        logic [NR-1:0] e_wait;
        logic          e_hw;
        logic [NR-1:0] e_rsp;
        logic          e_err;
    } vec_t;

    vec_t tbl [6];
    int   k031;
    int   guard;

    initial begin
        pClk_reset = 1'b1;
        req_write = '0; req_address = '0; req_burstcount = '0;
        req_writedata = '0; req_byteenable = '0;
        host_waitrequest = 1'b0; host_writeresponsevalid = 1'b0;
        for (int i = 0; i < NR; i++) begin
            cur_left[i] = 0; cur_bc[i] = 0; cur_beat[i] = 0; cur_id[i] = 0;
            cur_addr[i] = '0; acc[i] = 1'b0; rsp_cnt[i] = 0;
        end

        // Reset held: whatever the inputs do, the outputs stay quiescent.
        tbl[0] = '{2'b00, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b0};
        tbl[1] = '{2'b01, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b0};
        tbl[2] = '{2'b10, 1'b1, 1'b0, 2'b11, 1'b0, 2'b00, 1'b0};
        tbl[3] = '{2'b11, 1'b0, 1'b1, 2'b11, 1'b0, 2'b00, 1'b0};
        tbl[4] = '{2'b11, 1'b1, 1'b1, 2'b11, 1'b0, 2'b00, 1'b0};
        tbl[5] = '{2'b01, 1'b0, 1'b1, 2'b11, 1'b0, 2'b00, 1'b0};
        for (int v = 0; v < 6; v++) begin
            @(posedge pClk); #1;
            req_write = tbl[v].wr;
            host_waitrequest = tbl[v].hwait;
            host_writeresponsevalid = tbl[v].hrsp;
            @(negedge pClk); #1;
            chk("tbl_waitrequest", 64'(req_waitrequest), 64'(tbl[v].e_wait));
            chk("tbl_host_write", 64'(host_write), 64'(tbl[v].e_hw));
            chk("tbl_rsp_valid", 64'(req_writeresponsevalid), 64'(tbl[v].e_rsp));
            chk("tbl_underflow", 64'(rsp_underflow_err), 64'(tbl[v].e_err));
        end
        req_write = '0;
        host_writeresponsevalid = 1'b0;

        fork
            forever begin
                @(posedge pClk); #1;
                drive_step();
            end
        join_none

        // Single 4-beat burst: bubble, 4 beats, back to idle, one response.
        do_reset();
        pend[0].push_back(4);
        repeat (12) @(negedge pClk);
        #1;
        chk("t031_beats", 64'(host_beats), 64'd4);
        k031 = -1;
        for (int j = 0; j < rw_hist.size(); j++) if (rw_hist[j] && k031 < 0) k031 = j;
        chk("t031_hist_len", 64'(k031 >= 0 && hw_hist.size() >= k031 + 6), 64'd1);
        if (k031 >= 0 && hw_hist.size() >= k031 + 6) begin
            chk("t031_bubble", 64'(hw_hist[k031]), 64'd0);
            for (int j = 1; j <= 4; j++) chk("t031_beat_on", 64'(hw_hist[k031+j]), 64'd1);
            chk("t031_idle", 64'(hw_hist[k031+5]), 64'd0);
        end
        force_rsp = 1;
        repeat (3) @(negedge pClk);
        #1;
        chk("t031_rsp0", 64'(rsp_cnt[0]), 64'd1);

        // Two continuous requesters: grants and responses alternate.
        do_reset();
        rsp_mode = 1;
        for (int j = 0; j < 3; j++) begin
            pend[0].push_back(2);
            pend[1].push_back(2);
        end
        repeat (60) @(negedge pClk);
        #1;
        chk("t032_grants", 64'(grant_log.size()), 64'd6);
        chk("t032_rsps", 64'(rsp_log.size()), 64'd6);
        for (int j = 0; j < 6; j++) begin
            if (j < grant_log.size()) chk("t032_grant_order", 64'(grant_log[j]), 64'(j % 2));
            if (j < rsp_log.size()) chk("t032_rsp_order", 64'(rsp_log[j]), 64'(j % 2));
        end

        // Long req1 burst under toggling host stall keeps req0 out.
        do_reset();
        hw_mode = 2;
        pend[1].push_back(8);
        @(negedge pClk); #3;
        pend[0].push_back(1);
        repeat (40) @(negedge pClk);
        #1;
        chk("t033_grant_first", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'd1);
        chk("t033_beats", 64'(beat_log.size()), 64'd9);
        if (beat_log.size() == 9) begin
            for (int j = 0; j < 8; j++) chk("t033_req1_beat", 64'(beat_log[j]), 64'd1);
            chk("t033_req0_last", 64'(beat_log[8]), 64'd0);
        end

        // Response FIFO full blocks arbitration until one response returns.
        do_reset();
        for (int j = 0; j < 5; j++) pend[0].push_back(1);
        repeat (25) @(negedge pClk);
        #1;
        chk("t034_beats_blocked", 64'(host_beats), 64'd4);
        chk("t034_stalled", 64'(req_waitrequest), 64'b11);
        chk("t034_req_pending", 64'(req_write[0]), 64'd1);
        force_rsp = 1;
        repeat (8) @(negedge pClk);
        #1;
        chk("t034_beats_resumed", 64'(host_beats), 64'd5);

        // Response with nothing outstanding: sticky error, no pulse.
        do_reset();
        @(negedge pClk); #1;
        chk("t035_err_clear", 64'(rsp_underflow_err), 64'd0);
        force_rsp = 1;
        repeat (3) @(negedge pClk);
        #1;
        chk("t035_err_set", 64'(rsp_underflow_err), 64'd1);
        repeat (10) @(negedge pClk);
        #1;
        chk("t035_err_sticky", 64'(rsp_underflow_err), 64'd1);
        chk("t035_no_pulse", 64'(rsp_cnt[0] + rsp_cnt[1]), 64'd0);

        // Reset mid-burst abandons burst and outstanding response.
        do_reset();
        pend[0].push_back(4);
        guard = 0;
        do begin
            @(negedge pClk); #1;
            guard++;
        end while (host_beats < 2 && guard < 20);
        chk("t036_reach_beat2", 64'(host_beats == 2 && host_write), 64'd1);
        pClk_reset = 1'b1;
        #1;
        chk("t036_host_write", 64'(host_write), 64'd0);
        chk("t036_waitrequest", 64'(req_waitrequest), 64'b11);
        repeat (2) @(posedge pClk);
        @(negedge pClk); #2;
        pClk_reset = 1'b0;
        clear_logs();
        @(negedge pClk); #1;
        chk("t036_idle", 64'(host_write), 64'd0);
        force_rsp = 1;
        repeat (3) @(negedge pClk);
        #1;
        chk("t036_fifo_empty", 64'(rsp_underflow_err), 64'd1);
        chk("t036_no_pulse", 64'(rsp_cnt[0] + rsp_cnt[1]), 64'd0);

        // Randomized traffic under the cycle model.
        do_reset();
        gap_en = 1; hw_mode = 1; rsp_mode = 1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge pClk); #3;
            for (int i = 0; i < NR; i++)
                if (pend[i].size() < 2 && $urandom_range(0, 3) == 0)
                    pend[i].push_back(($urandom_range(0, 7) == 0) ?
                                      int'($urandom_range(1, 32)) :
                                      int'($urandom_range(1, 6)));
        end
        repeat (300) @(negedge pClk);
        #1;
        chk("rand_progress", 64'(host_beats > 100), 64'd1);
        chk("rand_no_underflow", 64'(rsp_underflow_err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
